// File: rtl/ahb_master_port.sv
// ---------------------------------------------------------------------------
// ahb_master_port
//   AHB-Lite initiator for the SDRAM controller's slave port. It accepts one
//   command at a time from a local client. A command is either a SINGLE word
//   or a 4-beat INCR4 burst. The block runs the pipelined address and data
//   phases, including wait states, and returns read beats plus a
//   completion/error status. It is the only master on the bus, so it also
//   drives h_sel.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (cmd_ready high only when idle)
//   cmd_write/cmd_burst  1 = write / 1 = INCR4
//   cmd_addr             first-beat word address
//   cmd_wdata            4 write beats, beat n at [n*DATA_W +: DATA_W]
//   rd_valid/rd_data     one pulse per completed read beat
//   done/err             completion pulse, err = bus error or timeout
//   h_*                  AHB-Lite master signals (all registered)
// ---------------------------------------------------------------------------
module ahb_master_port #(
   parameter int ADDR_W  = 25,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic                  cmd_burst,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [4*DATA_W-1:0]   cmd_wdata,
   output logic                  rd_valid,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  done,
   output logic                  err,
   output logic                  h_sel,
   output logic [1:0]            h_trans,
   output logic                  h_write,
   output logic [2:0]            h_burst,
   output logic [ADDR_W-1:0]     h_addr,
   output logic [DATA_W-1:0]     h_wdata,
   input  logic                  h_ready,
   input  logic                  h_resp,
   input  logic [DATA_W-1:0]     h_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;   // first address phase, no data yet
   localparam logic [1:0] S_BEAT = 2'd2;   // data of beat n overlaps address of beat n+1
   localparam logic [1:0] S_LAST = 2'd3;   // data phase of the final beat only

   localparam logic [1:0] HT_IDLE   = 2'd0;
   localparam logic [1:0] HT_NONSEQ = 2'd2;
   localparam logic [1:0] HT_SEQ    = 2'd3;
   localparam logic [2:0] HB_SINGLE = 3'b000;
   localparam logic [2:0] HB_INCR4  = 3'b011;

   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [1:0]          r_state;
   logic [1:0]          r_beat;     // index of the beat whose address is on the bus
   logic [4*DATA_W-1:0] r_wdata;    // remaining write beats, next one in the low word
   logic [TO_W-1:0]     r_to_cnt;   // consecutive h_ready=0 cycles

   logic w_accept;
   logic w_dphase;
   logic w_dp_ok;
   logic w_dp_err;
   logic w_timeout;
   logic w_abort;

   assign cmd_ready = (r_state == S_IDLE);
   assign w_accept  = cmd_valid && cmd_ready;

   // h_resp only means something while a data phase is in progress.
   assign w_dphase  = (r_state == S_BEAT) || (r_state == S_LAST);
   assign w_dp_ok   = w_dphase && h_ready && !h_resp;
   assign w_dp_err  = w_dphase && h_ready &&  h_resp;

   // This is the TIMEOUT-th consecutive stalled cycle.
   assign w_timeout = (r_state != S_IDLE) && !h_ready &&
                      (r_to_cnt == TO_W'(TIMEOUT - 1));
   assign w_abort   = w_dp_err || w_timeout;

   // NOTE: every register below is assigned with <= so all of them update
   // together from the values held before the edge, matching the AHB pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_beat   <= '0;
         r_wdata  <= '0;
         r_to_cnt <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         h_sel    <= 1'b0;
         h_trans  <= HT_IDLE;
         h_write  <= 1'b0;
         h_burst  <= HB_SINGLE;
         h_addr   <= '0;
         h_wdata  <= '0;
      end else begin
         rd_valid <= 1'b0;
         done     <= 1'b0;

         if (h_ready || (r_state == S_IDLE)) begin
            r_to_cnt <= '0;
         end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end

         if (w_dp_ok && !h_write) begin
            rd_valid <= 1'b1;
            rd_data  <= h_rdata;
         end

         if (w_abort) begin
            // The erroring beat and every later beat are dropped.
            h_trans <= HT_IDLE;
            h_sel   <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_accept) begin
                     h_sel   <= 1'b1;
                     h_trans <= HT_NONSEQ;
                     h_addr  <= cmd_addr;
                     h_write <= cmd_write;
                     h_burst <= cmd_burst ? HB_INCR4 : HB_SINGLE;
                     r_wdata <= cmd_wdata;
                     r_beat  <= 2'd0;
                     err     <= 1'b0;
                     r_state <= S_ADDR;
                  end
               end
               S_ADDR: begin
                  if (h_ready) begin
                     // The address was accepted, so its data phase starts
                     // next cycle with that beat's write word.
                     h_wdata <= r_wdata[DATA_W-1:0];
                     r_wdata <= {{DATA_W{1'b0}}, r_wdata[4*DATA_W-1:DATA_W]};
                     if (h_burst == HB_INCR4) begin
                        h_trans <= HT_SEQ;
                        h_addr  <= h_addr + ADDR_W'(1);
                        r_beat  <= 2'd1;
                        r_state <= S_BEAT;
                     end else begin
                        h_trans <= HT_IDLE;
                        r_state <= S_LAST;
                     end
                  end
               end
               S_BEAT: begin
                  // h_resp=1 with h_ready=1 was already handled as an abort.
                  if (h_ready) begin
                     h_wdata <= r_wdata[DATA_W-1:0];
                     r_wdata <= {{DATA_W{1'b0}}, r_wdata[4*DATA_W-1:DATA_W]};
                     if (r_beat == 2'd3) begin
                        h_trans <= HT_IDLE;
                        r_state <= S_LAST;
                     end else begin
                        // Wraps modulo 2^ADDR_W with no 1 KB boundary split.
                        h_addr <= h_addr + ADDR_W'(1);
                        r_beat <= r_beat + 2'd1;
                     end
                  end
               end
               S_LAST: begin
                  if (h_ready) begin
                     h_sel   <= 1'b0;
                     done    <= 1'b1;
                     err     <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
